uart_rx_sequencer: RTL and testbench

Bit-level sequencer for the UART receive path. Watches the serial line at 16x oversampling, validates the start bit at mid-bit, and issues one shift strobe per data bit to the external receive shift register. It then checks the stop bit and signals frame completion or framing error. It replaces the coarse enable-only RX controller and drives the same shift-register datapath.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_sync_2ff.sv | 41 ++++
 rtl/uart_rx_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_uart_rx_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path and its baud generator.
//   OVERSAMPLE_DEFAULT : baud_tick pulses per bit period
//   rx_state_t         : receive sequencer states
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

endpackage

// File: rtl/uart_sync_2ff.sv
// ---------------------------------------------------------------------------
// uart_sync_2ff
// Two-flop synchronizer for an asynchronous serial line. Both stages reset
// to 1 so an idle (high) line never looks like a start bit coming out of
// reset. Shared with the TX loopback path.
// Ports:
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset
//   d        in  asynchronous input
//   q        out synchronized output, 2 clk latency
// ---------------------------------------------------------------------------
module uart_sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic meta_d;
  logic sync_q;
  logic sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_sequencer.sv
// ---------------------------------------------------------------------------
// uart_rx_sequencer
// Bit-level sequencer for the UART receive path. Validates the start bit at
// mid-bit, strobes each data bit (LSB first) into an external shift
// register, then checks the stop bit.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : PARITY state compiled in, parity_err live, PARITY_ODD selects
//               even (0) / odd (1) parity
//   undefined : frame = start + DATA_BITS + stop, parity_err tied to 0
//
// Ports:
//   clk         in  system clock
//   reset_n     in  asynchronous active-low reset
//   enable      in  receiver enable; low forces IDLE on the next clk
//   baud_tick   in  single-clk pulse at OVERSAMPLE x baud rate
//   serial_in   in  asynchronous serial line, idle high
//   shift_en    out one-clk strobe: shift shift_bit into the shift register
//   shift_bit   out sampled data bit, valid with shift_en
//   done_rx     out one-clk pulse at the stop-bit sample
//   frame_err   out one-clk pulse with done_rx when the stop bit is 0
//   parity_err  out one-clk pulse with done_rx on parity mismatch
//   busy        out high in every state except IDLE
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | line idle, waiting for a tick with the line low
// START  | counting to mid start bit; line high there is a false start
// DATA   | sampling DATA_BITS data bits at mid-bit
// PARITY | sampling the parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit; reports done and errors
// BREAK  | line held low after a bad stop bit; waits for line high
// ---------------------------------------------------------------------------
module uart_rx_sequencer
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic baud_tick,
  input  logic serial_in,
  output logic shift_en,
  output logic shift_bit,
  output logic done_rx,
  output logic frame_err,
  output logic parity_err,
  output logic busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic rx_s;

  rx_state_t       state_q, state_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic            shift_en_q, shift_en_d;
  logic            shift_bit_q, shift_bit_d;
  logic            done_rx_q, done_rx_d;
  logic            frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic            parity_err_q, parity_err_d;
  logic            par_acc_q, par_acc_d;   // running XOR of the data bits
  logic            par_bad_q, par_bad_d;   // mismatch held until the stop sample
`endif

  uart_sync_2ff u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (serial_in),
    .q       (rx_s)
  );

  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    bcnt_d      = bcnt_q;
    shift_en_d  = 1'b0;
    shift_bit_d = 1'b0;
    done_rx_d   = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_d = 1'b0;
    par_acc_d    = par_acc_q;
    par_bad_d    = par_bad_q;
`endif

    // The enable check sits ahead of the tick so an abort wins over a tick
    // landing in the same clk.
    if (!enable) begin
      state_d = IDLE;
      tcnt_d  = '0;
      bcnt_d  = '0;
`ifdef UART_RX_PARITY_EN
      par_acc_d = 1'b0;
      par_bad_d = 1'b0;
`endif
    end else if (baud_tick) begin
      case (state_q)
        IDLE: begin
          tcnt_d = '0;
          bcnt_d = '0;
`ifdef UART_RX_PARITY_EN
          par_acc_d = 1'b0;
          par_bad_d = 1'b0;
`endif
          if (!rx_s) begin
            state_d = START;
          end
        end

        START: begin
          if (tcnt_q == T_HALF) begin
            tcnt_d  = '0;
            state_d = rx_s ? IDLE : DATA;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end

        DATA: begin
          if (tcnt_q == T_LAST) begin
            shift_en_d  = 1'b1;
            shift_bit_d = rx_s;
            tcnt_d      = '0;
            bcnt_d      = bcnt_q + BW'(1);
`ifdef UART_RX_PARITY_EN
            par_acc_d   = par_acc_q ^ rx_s;
`endif
            if (bcnt_q == B_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tcnt_q == T_LAST) begin
            // Even parity expects the bit to equal the data XOR; odd inverts it.
            par_bad_d = rx_s ^ par_acc_q ^ PARITY_ODD;
            tcnt_d    = '0;
            state_d   = STOP;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
`endif

        STOP: begin
          if (tcnt_q == T_LAST) begin
            done_rx_d   = 1'b1;
            frame_err_d = ~rx_s;
`ifdef UART_RX_PARITY_EN
            parity_err_d = par_bad_q;
`endif
            tcnt_d  = '0;
            bcnt_d  = '0;
            state_d = rx_s ? IDLE : BREAK;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end

        BREAK: begin
          if (rx_s) begin
            state_d = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
          tcnt_d  = '0;
          bcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      tcnt_q      <= '0;
      bcnt_q      <= '0;
      shift_en_q  <= 1'b0;
      shift_bit_q <= 1'b0;
      done_rx_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
      par_acc_q    <= 1'b0;
      par_bad_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      bcnt_q      <= bcnt_d;
      shift_en_q  <= shift_en_d;
      shift_bit_q <= shift_bit_d;
      done_rx_q   <= done_rx_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_d;
      par_acc_q    <= par_acc_d;
      par_bad_q    <= par_bad_d;
`endif
    end
  end

  assign shift_en  = shift_en_q;
  assign shift_bit = shift_bit_q;
  assign done_rx   = done_rx_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_sequencer
// Directed and random frames driven on serial_in; received strobes and
// done/error pulses are collected by a monitor and compared with values
// computed from the frame contents. Build with +define+UART_RX_PARITY_EN
// to include the parity frames.
// ---------------------------------------------------------------------------
module tb_uart_rx_sequencer;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int TICK_DIV   = 4;
  localparam bit PARITY_ODD_TB = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic enable;
  logic baud_tick;
  logic serial_in;
  logic shift_en;
  logic shift_bit;
  logic done_rx;
  logic frame_err;
  logic parity_err;
  logic busy;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  uart_rx_sequencer #(
    .DATA_BITS  (DATA_BITS),
    .OVERSAMPLE (OVERSAMPLE)
`ifdef UART_RX_PARITY_EN
    ,
    .PARITY_ODD (PARITY_ODD_TB)
`endif
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .baud_tick  (baud_tick),
    .serial_in  (serial_in),
    .shift_en   (shift_en),
    .shift_bit  (shift_bit),
    .done_rx    (done_rx),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  // baud tick generator: one clk high every TICK_DIV clks
  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
    end
  end

  int tick_cnt = 0;
  always @(posedge clk) begin
    if (baud_tick) tick_cnt <= tick_cnt + 1;
  end

  // monitor
  logic bits_q[$];
  int   done_cnt   = 0;
  int   orphan_cnt = 0;
  logic last_ferr  = 1'b0;
  logic last_perr  = 1'b0;

  always @(negedge clk) begin
    if (shift_en) bits_q.push_back(shift_bit);
    if (done_rx) begin
      done_cnt  <= done_cnt + 1;
      last_ferr <= frame_err;
      last_perr <= parity_err;
    end
    if ((frame_err || parity_err) && !done_rx) orphan_cnt <= orphan_cnt + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int t0;
    t0 = tick_cnt;
    while (tick_cnt < t0 + n) @(negedge clk);
    #1;
  endtask

  function automatic logic good_par(input logic [7:0] d);
    int c;
    c = $countones(d);
    return ((c % 2) == 1) ^ PARITY_ODD_TB;
  endfunction

  function automatic logic exp_perr(input logic [7:0] d, input logic p);
    int c;
    c = $countones(d) + int'(p);
    return PAR_ON && ((c % 2) != int'(PARITY_ODD_TB));
  endfunction

  task automatic send_frame(input logic [7:0] data, input logic pbit,
                            input logic stop, input int stop_ticks);
    serial_in = 1'b0;
    wait_ticks(OVERSAMPLE);
    for (int i = 0; i < DATA_BITS; i++) begin
      serial_in = data[i];
      wait_ticks(OVERSAMPLE);
    end
    if (PAR_ON) begin
      serial_in = pbit;
      wait_ticks(OVERSAMPLE);
    end
    serial_in = stop;
    wait_ticks(stop_ticks);
    serial_in = 1'b1;
  endtask

  task automatic check_frame(input string tag, input int b0, input int d0,
                             input logic [7:0] data, input logic pbit, input logic stop);
    logic [7:0] got;
    got = '0;
    for (int i = 0; i < DATA_BITS; i++) begin
      if (b0 + i < bits_q.size()) got[i] = bits_q[b0 + i];
    end
    chk({tag, "_nstrobes"}, bits_q.size() - b0, DATA_BITS);
    chk({tag, "_data"}, got, data);
    chk({tag, "_ndone"}, done_cnt - d0, 1);
    chk({tag, "_frame_err"}, last_ferr, !stop);
    chk({tag, "_parity_err"}, last_perr, exp_perr(data, pbit));
  endtask

  initial begin
    int b0;
    int d0;
    int n;
    logic [7:0] rd;

    reset_n   = 1'b0;
    enable    = 1'b1;
    serial_in = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("rst_shift_en", shift_en, 0);
    chk("rst_shift_bit", shift_bit, 0);
    chk("rst_done_rx", done_rx, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_parity_err", parity_err, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    wait_ticks(4);

    // 0xA5 8N1
    b0 = bits_q.size(); d0 = done_cnt;
    send_frame(8'hA5, good_par(8'hA5), 1'b1, OVERSAMPLE);
    check_frame("a5", b0, d0, 8'hA5, good_par(8'hA5), 1'b1);
    chk("a5_busy_after", busy, 0);

    // 4-tick low glitch: false start
    b0 = bits_q.size(); d0 = done_cnt;
    serial_in = 1'b0;
    wait_ticks(3);
    chk("glitch_busy_start", busy, 1);
    wait_ticks(1);
    serial_in = 1'b1;
    wait_ticks(10);
    chk("glitch_busy_end", busy, 0);
    chk("glitch_nstrobes", bits_q.size() - b0, 0);
    chk("glitch_ndone", done_cnt - d0, 0);

    // 0x3C with stop bit 0, line low 40 more ticks
    b0 = bits_q.size(); d0 = done_cnt;
    send_frame(8'h3C, good_par(8'h3C), 1'b0, OVERSAMPLE + 40);
    check_frame("brk", b0, d0, 8'h3C, good_par(8'h3C), 1'b0);
    chk("brk_busy_low", busy, 1);
    wait_ticks(4);
    chk("brk_busy_released", busy, 0);
    wait_ticks(20);
    chk("brk_no_spurious_strobe", bits_q.size() - b0, DATA_BITS);
    chk("brk_no_spurious_done", done_cnt - d0, 1);

    // abort after the 3rd strobe of 0x55
    b0 = bits_q.size(); d0 = done_cnt;
    serial_in = 1'b0;
    wait_ticks(OVERSAMPLE);
    serial_in = 1'b1;
    wait_ticks(OVERSAMPLE);
    serial_in = 1'b0;
    wait_ticks(OVERSAMPLE);
    serial_in = 1'b1;
    n = 0;
    while (bits_q.size() < b0 + 3 && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    enable = 1'b0;
    chk("abort_strobes_before", bits_q.size() - b0, 3);
    @(negedge clk);
    #1;
    chk("abort_busy_next_clk", busy, 0);
    rd = '0;
    for (int i = 0; i < 3; i++) begin
      if (b0 + i < bits_q.size()) rd[i] = bits_q[b0 + i];
    end
    chk("abort_bits", rd[2:0], 3'b101);
    wait_ticks(OVERSAMPLE * 8);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_no_more_strobes", bits_q.size() - b0, 3);
    enable = 1'b1;
    wait_ticks(4);
    b0 = bits_q.size(); d0 = done_cnt;
    send_frame(8'h55, good_par(8'h55), 1'b1, OVERSAMPLE);
    check_frame("after_abort", b0, d0, 8'h55, good_par(8'h55), 1'b1);

`ifdef UART_RX_PARITY_EN
    b0 = bits_q.size(); d0 = done_cnt;
    send_frame(8'h07, 1'b0, 1'b1, OVERSAMPLE);
    check_frame("par_bad", b0, d0, 8'h07, 1'b0, 1'b1);
    b0 = bits_q.size(); d0 = done_cnt;
    send_frame(8'h07, 1'b1, 1'b1, OVERSAMPLE);
    check_frame("par_good", b0, d0, 8'h07, 1'b1, 1'b1);
`endif

    // reset in the middle of DATA
    serial_in = 1'b0;
    wait_ticks(OVERSAMPLE * 4);
    chk("midrst_busy_before", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_shift_en", shift_en, 0);
    chk("midrst_done_rx", done_rx, 0);
    chk("midrst_frame_err", frame_err, 0);
    serial_in = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_ticks(4);
    b0 = bits_q.size(); d0 = done_cnt;
    send_frame(8'hFF, good_par(8'hFF), 1'b1, OVERSAMPLE);
    check_frame("post_rst_ff", b0, d0, 8'hFF, good_par(8'hFF), 1'b1);

    // random frames with random gaps, including back-to-back
    for (int k = 0; k < 8; k++) begin
      rd = 8'($urandom);
      b0 = bits_q.size(); d0 = done_cnt;
      send_frame(rd, good_par(rd), 1'b1, OVERSAMPLE);
      check_frame($sformatf("rand%0d", k), b0, d0, rd, good_par(rd), 1'b1);
      wait_ticks(int'($urandom_range(0, 12)));
    end

    wait_ticks(4);
    chk("final_busy", busy, 0);
    chk("orphan_err_pulses", orphan_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
